// File: rtl/we_control.sv
// we_control: write-side pointer, full/level/almost-full and sticky overflow control of a dual-clock FIFO
// Optional macro WE_SYNC_EN adds a two-flop synchronizer on rptr_wclk.
module we_control #(
  parameter int ADDRWIDTH    = 4,
  parameter int AFULL_THRESH = 12
) (
  input  logic                 wclk,
  input  logic                 wrstn,
  input  logic                 wpush,
  input  logic                 wovf_clr,
  input  logic [ADDRWIDTH:0]   rptr_wclk,
  output logic                 wen,
  output logic [ADDRWIDTH-1:0] waddr,
  output logic [ADDRWIDTH:0]   wptr,
  output logic                 wfull,
  output logic [ADDRWIDTH:0]   wlevel,
  output logic                 walmost_full,
  output logic                 woverflow
);
  localparam int AW = ADDRWIDTH;
  localparam logic [AW:0] THRESH = (AW+1)'(AFULL_THRESH);
  logic [AW:0] wbin, wbin_next, wgray_next, rq, rbin_w, diff;
`ifdef WE_SYNC_EN
  logic [AW:0] rsync1, rsync2;
  always_ff @(posedge wclk or negedge wrstn)
    if (!wrstn) begin
      rsync1 <= '0;
      rsync2 <= '0;
    end else begin
      rsync1 <= rptr_wclk;
      rsync2 <= rsync1;
    end
  assign rq = rsync2;
`else
  assign rq = rptr_wclk;
`endif
  // Each binary bit is the XOR of all Gray bits from the MSB down to it
  for (genvar i = 0; i <= AW; i++) begin : g_g2b
    assign rbin_w[i] = ^rq[AW:i];
  end
  assign wen        = wpush & ~wfull;
  assign waddr      = wbin[AW-1:0];
  assign wbin_next  = wbin + {{AW{1'b0}}, wen};
  assign wgray_next = (wbin_next >> 1) ^ wbin_next;
  assign diff       = wbin_next - rbin_w;
  always_ff @(posedge wclk or negedge wrstn)
    if (!wrstn) begin
      wbin         <= '0;
      wptr         <= '0;
      wfull        <= 1'b0;
      wlevel       <= '0;
      walmost_full <= 1'b0;
      woverflow    <= 1'b0;
    end else begin
      wbin         <= wbin_next;
      wptr         <= wgray_next;
      wfull        <= wgray_next == {~rq[AW:AW-1], rq[AW-2:0]};
      wlevel       <= diff;
      walmost_full <= diff >= THRESH;
      woverflow    <= (wpush & wfull) ? 1'b1 : wovf_clr ? 1'b0 : woverflow;
    end
endmodule

// File: tb/tb_we_control.sv
// tb_we_control: directed self-checking bench for we_control (ADDRWIDTH=4, AFULL_THRESH=12)
module tb_we_control;
  logic       wclk = 1'b0, wrstn = 1'b0, wpush = 1'b0, wovf_clr = 1'b0;
  logic [4:0] rptr_wclk = '0;
  logic       wen, wfull, walmost_full, woverflow;
  logic [3:0] waddr;
  logic [4:0] wptr, wlevel, prev, wb;
  int n_cmp = 0, n_bad = 0;
`ifdef WE_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  we_control #(.ADDRWIDTH(4), .AFULL_THRESH(12)) dut (
    .wclk(wclk), .wrstn(wrstn), .wpush(wpush), .wovf_clr(wovf_clr),
    .rptr_wclk(rptr_wclk), .wen(wen), .waddr(waddr), .wptr(wptr),
    .wfull(wfull), .wlevel(wlevel), .walmost_full(walmost_full), .woverflow(woverflow)
  );

  always #5 wclk = ~wclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge wclk);
    #1;
  endtask

  task automatic do_reset;
    wpush = 0; wovf_clr = 0; rptr_wclk = '0; wrstn = 0;
    repeat (2) tick();
    wrstn = 1;
  endtask

  task automatic fill16;
    for (int i = 0; i < 16; i++) begin
      wpush = 1;
      #1;
      chk("fill_wen", wen, 1);
      chk("fill_waddr", waddr, i);
      tick();
      chk("fill_level", wlevel, i + 1);
      chk("fill_afull", walmost_full, (i + 1) >= 12);
      chk("fill_full", wfull, i == 15);
    end
    wpush = 0;
  endtask

  function automatic logic [4:0] gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  initial begin
    // 1: reset state
    do_reset();
    #1;
    chk("rst_wptr", wptr, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_full", wfull, 0);
    chk("rst_level", wlevel, 0);
    chk("rst_afull", walmost_full, 0);
    chk("rst_ovf", woverflow, 0);
    // 2: fill
    fill16();
    chk("full_wptr", wptr, 5'b11000);
    // 3: pushes while full are dropped and flagged
    for (int i = 0; i < 3; i++) begin
      wpush = 1;
      #1;
      chk("ovf_wen", wen, 0);
      chk("ovf_waddr", waddr, 0);
      tick();
      chk("ovf_wptr", wptr, 5'b11000);
      chk("ovf_flag", woverflow, 1);
    end
    wpush = 0; wovf_clr = 1;
    tick();
    chk("ovf_clr", woverflow, 0);
    wovf_clr = 0;
    // 4: one read releases full, one push refills
    rptr_wclk = 5'b00001;
    tick();
    chk("rd_full", wfull, 0);
    chk("rd_level", wlevel, 15);
    wpush = 1;
    #1;
    chk("rd_wen", wen, 1);
    tick();
    wpush = 0;
    chk("refill_full", wfull, 1);
    chk("refill_wptr", wptr, 5'b11001);
    chk("refill_level", wlevel, 16);
    // 5: sustained stream across the pointer wrap
    do_reset();
    wpush = 1;
    repeat (2) tick();
    chk("str_pre_level", wlevel, 2);
    wb = 5'd2;
    for (int i = 0; i < 40; i++) begin
      prev = wptr;
      rptr_wclk = gray(wb - 5'd1);
      #1;
      chk("str_wen", wen, 1);
      chk("str_waddr", waddr, wb[3:0]);
      tick();
      wb = wb + 5'd1;
      chk("str_wptr", wptr, gray(wb));
      chk("str_onebit", $countones(wptr ^ prev), 1);
      chk("str_level", wlevel, 2);
      chk("str_full", wfull, 0);
    end
    wpush = 0;
    // asynchronous reset mid-cycle
    @(posedge wclk);
    #2 wrstn = 0;
    #1;
    chk("async_waddr", waddr, 0);
    chk("async_wptr", wptr, 0);
    chk("async_level", wlevel, 0);
    // 6: set beats clear, read latency through the synchronizer
    do_reset();
    fill16();
    wpush = 1; wovf_clr = 1;
    tick();
    wpush = 0; wovf_clr = 0;
    chk("setwins_ovf", woverflow, 1);
    rptr_wclk = gray(5'd1);
    for (int c = 1; c <= LAT; c++) begin
      tick();
      chk("lat_full", wfull, c < LAT);
    end
    chk("lat_level", wlevel, 15);
    chk("lat_ovf", woverflow, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/we_control.md
Name: we_control

Overview:
- Write-side control for the dual-clock asynchronous FIFO; the counterpart of the read-side control block.
- Runs entirely in the write clock domain.
- Owns the binary write counter, the memory write address and the Gray-coded write pointer sent to the read domain.
- Derives full, fill level, almost-full and overflow status from the read pointer synchronized into the write domain.

Parameters:
- ADDRWIDTH, 4, memory address width; depth DEPTH = 2^ADDRWIDTH; legal values >= 2.
- AFULL_THRESH, 12, fill level at or above which walmost_full asserts; legal range 1..DEPTH.

Ports:
- wclk  input  1  write-domain clock, rising edge.
- wrstn  input  1  reset, asynchronous assert, active-low; deasserted synchronously to wclk externally.
- wpush  input  1  write request; data is accepted this cycle when wpush=1 and wfull=0.
- wovf_clr  input  1  clears the sticky overflow flag.
- rptr_wclk  input  ADDRWIDTH+1  Gray read pointer in the write domain; see WE_SYNC_EN.
- wen  output  1  memory write enable, combinational: wpush & ~wfull.
- waddr  output  ADDRWIDTH  memory write address = wbin[ADDRWIDTH-1:0].
- wptr  output  ADDRWIDTH+1  registered Gray write pointer, to the read-domain synchronizer.
- wfull  output  1  registered full flag.
- wlevel  output  ADDRWIDTH+1  registered fill level, 0..DEPTH.
- walmost_full  output  1  registered, wlevel >= AFULL_THRESH.
- woverflow  output  1  sticky flag: a push was attempted while full.

Behaviour:
- Reset (wrstn=0, asynchronous): wbin=0, wptr=0, wfull=0, wlevel=0, walmost_full=0, woverflow=0. waddr follows wbin, so it is 0.
- wbin_next = wbin + 1 when wen=1, else wbin. Arithmetic is ADDRWIDTH+1 bits and wraps modulo 2^(ADDRWIDTH+1).
- wgray_next = (wbin_next >> 1) ^ wbin_next.
- Every wclk edge: wbin <= wbin_next; wptr <= wgray_next.
- Full: wfull <= (wgray_next == {~rq[AW:AW-1], rq[AW-2:0]}), where rq is the effective synchronized read pointer.
  - Full is evaluated on the next-state pointer, so the flag is valid in the cycle after the filling write.
  - Full deasserts only after a read propagates through synchronization; this is a pessimistic release.
- Level: rbin_w = Gray-to-binary(rq), using an XOR prefix from the MSB.
  - wlevel <= wbin_next - rbin_w, truncated to ADDRWIDTH+1 bits; the value is never greater than DEPTH.
  - walmost_full <= (wbin_next - rbin_w) >= AFULL_THRESH, computed on the same cycle's values as wlevel.
- Overflow:
  - A push while wfull=1 is dropped: no pointer change, wen=0.
  - woverflow <= 1 when wpush & wfull.
  - Otherwise woverflow <= 0 when wovf_clr.
  - If set and clear occur in the same cycle, set wins.
- Wrap-around: after 2^(ADDRWIDTH+1) accepted writes, wbin returns to 0. The MSB toggle distinguishes full from empty.
- Simultaneous push and rq update in the same cycle: both are used in the next-state computation; no priority conflict.
- Reset mid-operation: all state clears immediately; waddr returns to 0 asynchronously.
- No combinational path from rptr_wclk to any output.

Optional Feature:
- Macro WE_SYNC_EN.
- Defined:
  - rptr_wclk is treated as the raw read-domain Gray pointer.
  - Two wclk flops, reset to 0, form rq.
  - Full and level see a read 2 cycles later than without the macro.
- Undefined: rq = rptr_wclk directly; synchronization is done externally.

Test Plan:
All cases use ADDRWIDTH=4, AFULL_THRESH=12, WE_SYNC_EN undefined, rptr_wclk held at 0 unless stated.
1. Reset release, wpush=0 -> wptr=0, waddr=0, wfull=0, wlevel=0, walmost_full=0, woverflow=0.
2. Push 16 consecutive cycles:
   - waddr steps 0..15 and wen=1 each cycle.
   - walmost_full=1 one cycle after the 12th push.
   - wfull=1 and wlevel=16 one cycle after the 16th push; wptr=5'b11000.
3. Full, wpush=1 for 3 cycles -> wen=0, waddr stays 0, wptr unchanged, woverflow=1. Then wovf_clr=1 with wpush=0 -> woverflow=0 next cycle.
4. Full, set rptr_wclk=5'b00001 (read count 1) -> next cycle wfull=0, wlevel=15. One push -> wfull=1, wptr=Gray(17)=5'b11001.
5. Sustained stream of 40 accepted pushes with rptr_wclk tracking Gray(wbin-2):
   - wbin wraps 31->0; wptr follows the Gray sequence (one bit change per step).
   - wlevel stays 2 and wfull never asserts.
6. With WE_SYNC_EN defined, full FIFO, rptr_wclk changed to Gray(1) -> wfull deasserts exactly 3 cycles later (2 sync flops plus the status register); wovf_clr and wpush asserted together while full -> woverflow stays 1.
